// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing the Address_Register / memory port between instruction
// fetch (read-only) and data access (read/write); sequences LOAD, WAIT and DONE phases.
module mem_access_arbiter #(
  parameter int ws          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [ws-1:0] fetch_addr,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [ws-1:0] data_addr,
  input  logic [ws-1:0] data_wdata,
  input  logic [ws-1:0] mem_rdata,
  output logic          fetch_ack,
  output logic          data_ack,
  output logic [ws-1:0] rdata,
  output logic          load_add_r,
  output logic [ws-1:0] bus_addr,
  output logic          mem_wr,
  output logic [ws-1:0] mem_wdata,
  output logic          busy
);

  // Handshake: a requester raises req and holds it (with stable operands) until its
  // one-cycle ack; req is only sampled in IDLE, so inputs are don't-care while busy.

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t        state;
  logic          last_data;
  logic          grant_data;
  logic          grant_we;
  logic [ws-1:0] grant_addr;
  logic [ws-1:0] grant_wdata;
  logic [3:0]    wait_cnt;
  logic          pick_data;

  // Data wins when it is the only requester, or on a tie when fetch was served last.
  assign pick_data = data_req && (!fetch_req || !last_data);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_data   <= 1'b1;
      grant_data  <= 1'b0;
      grant_we    <= 1'b0;
      grant_addr  <= '0;
      grant_wdata <= '0;
      wait_cnt    <= '0;
      fetch_ack   <= 1'b0;
      data_ack    <= 1'b0;
      rdata       <= '0;
      load_add_r  <= 1'b0;
      bus_addr    <= '0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      load_add_r <= 1'b0;
      bus_addr   <= '0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      fetch_ack  <= 1'b0;
      data_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req || data_req) begin
            grant_data  <= pick_data;
            last_data   <= pick_data;
            grant_we    <= pick_data && data_we;
            grant_addr  <= pick_data ? data_addr : fetch_addr;
            grant_wdata <= pick_data ? data_wdata : '0;
            load_add_r  <= 1'b1;
            bus_addr    <= pick_data ? data_addr : fetch_addr;
            state       <= LOAD;
          end
        end
        LOAD: begin
          wait_cnt  <= 4'(WAIT_CYCLES - 1);
          mem_wr    <= grant_we;
          mem_wdata <= grant_wdata;
          state     <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            if (!grant_we) rdata <= mem_rdata;
            fetch_ack <= !grant_data;
            data_ack  <= grant_data;
            state     <= DONE;
          end else begin
            wait_cnt  <= wait_cnt - 4'd1;
            mem_wdata <= grant_wdata;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
